convenc_frame_ctrl: RTL

//  Frame sequencer for the rate-1/2 K=3 convolutional encoder. Accepts payload words over a

---
 rtl/convenc_pkg.sv | 18 +
 rtl/convenc_frame_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/convenc_pkg.sv
// Shared definitions for the K=3 convolutional encoder and its frame sequencer.
//   CONVENC_K      constraint length of the encoder
//   TAIL_BITS_DEF  flush bits needed to return the encoder to the all-zero state
//   state_t        frame sequencer state encoding
package convenc_pkg;

  localparam int CONVENC_K     = 3;
  localparam int TAIL_BITS_DEF = CONVENC_K - 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_WAIT  = 3'd2,
    ST_TAIL  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/convenc_frame_ctrl.sv
// Frame sequencer feeding a rate-1/2 K=3 convolutional encoder.
// Serializes payload words from a valid/ready stream into in_valid/bit_in of the
// encoder, then appends TAIL_BITS zero bits after the last word of each frame so
// the encoder ends in the all-zero state.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   s_valid/s_ready       payload handshake; s_data word, s_last marks final word
//   enc_ready             downstream can accept a bit this cycle
//   enc_valid, enc_bit    bit stream to the encoder
//   enc_tail              current enc_bit is a flush bit
//   frame_start           pulse on the cycle the first payload bit is offered
//   frame_done            pulse on the cycle after the last tail bit is consumed
//   busy                  sequencer not idle
//   bit_count             bits fed in current/last frame, saturating
module convenc_frame_ctrl
  import convenc_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int TAIL_BITS = TAIL_BITS_DEF,  // legal range 1..15
  parameter int CNT_W     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              enc_ready,
  output logic              enc_valid,
  output logic              enc_bit,
  output logic              enc_tail,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int               IDX_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic [3:0]       TAIL_LAST = 4'(TAIL_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic              last_q;
  logic [3:0]        tail_cnt;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              frame_start_q;

  logic              cur_bit;
  logic              final_bit;
  logic              load;
  logic              advance;

  assign cur_bit   = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];
  assign final_bit = (bit_idx == LAST_IDX);
  // A word is taken whenever the handshake completes: IDLE, WAIT or the
  // zero-bubble reload on the final bit of the current word.
  assign load      = s_valid && s_ready;
  assign advance   = (state == ST_SHIFT) && enc_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (s_valid) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (enc_ready && final_bit) begin
          if (last_q)       state_nxt = ST_TAIL;
          else if (s_valid) state_nxt = ST_SHIFT;
          else              state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (s_valid) state_nxt = ST_SHIFT;
      end
      ST_TAIL: begin
        if (enc_ready && (tail_cnt == TAIL_LAST)) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    s_ready   = 1'b0;
    enc_valid = 1'b0;
    enc_bit   = 1'b0;
    enc_tail  = 1'b0;
    case (state)
      ST_IDLE:  s_ready = 1'b1;
      ST_SHIFT: begin
        enc_valid = enc_ready;
        enc_bit   = cur_bit;
        // Only the final bit of a non-last word can pull in the next word.
        s_ready   = enc_ready && final_bit && !last_q && s_valid;
      end
      ST_WAIT:  s_ready = 1'b1;
      ST_TAIL: begin
        enc_valid = enc_ready;
        enc_tail  = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      s_ready   = 1'b0;
      enc_valid = 1'b0;
    end
  end

  // Shift register, bit index, tail counter, frame counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg         <= '0;
      bit_idx       <= '0;
      last_q        <= 1'b0;
      tail_cnt      <= '0;
      bit_cnt_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= load && (state == ST_IDLE);
      if (load) begin
        shreg    <= s_data;
        last_q   <= s_last;
        bit_idx  <= '0;
        tail_cnt <= '0;
      end else if (advance && !final_bit) begin
        shreg   <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
        bit_idx <= bit_idx + IDX_W'(1);
      end else if ((state == ST_TAIL) && enc_ready) begin
        tail_cnt <= tail_cnt + 4'd1;
      end
      if (load && (state == ST_IDLE)) begin
        bit_cnt_q <= '0;
      end else if (enc_valid && (bit_cnt_q != CNT_MAX)) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
    end
  end

  assign frame_start = frame_start_q;
  assign frame_done  = (state == ST_DONE);
  assign busy        = (state != ST_IDLE);
  assign bit_count   = bit_cnt_q;

endmodule
